// File: rtl/out_channel_drain_if.sv
// Handshake bundle between the core's out channel and the downstream stream consumer.
interface out_channel_drain_if #(
   parameter int MemoryElementWidth = 12
);
   logic                          wr_en;
   logic [MemoryElementWidth-1:0] wr_data;
   logic                          out_valid;
   logic [MemoryElementWidth-1:0] out_data;
   logic                          out_ready;

   // master: core writes and consumer ready; slave: the drain FIFO itself
   modport master (
      output wr_en, wr_data, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  wr_en, wr_data, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/out_channel_drain.sv
// Buffers the core's out-channel words in a FIFO and streams them out in order.
// Optional words_out pop counter is enabled with `define OUT_DRAIN_STATS_EN.
module out_channel_drain #(
   parameter int MemoryElementWidth = 12,
   parameter int Depth              = 4
) (
   input  logic              clock,
   input  logic              reset,
   out_channel_drain_if.slave bus,
   input  logic              finished,
   output logic              full,
   output logic              overflow,
   output logic              drained
`ifdef OUT_DRAIN_STATS_EN
   ,
   output logic [15:0]       words_out
`endif
);
   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                        state;
   logic [MemoryElementWidth-1:0] mem [Depth];
   logic [PW-1:0]                 rd_ptr;
   logic [PW-1:0]                 wr_ptr;
   logic [CW-1:0]                 count;
   logic                          pop;
   logic                          push;
   logic                          drop;

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign full          = (count == DEPTH_C);
   assign drained       = (state == DONE);

   // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts.
   assign pop  = bus.out_valid && bus.out_ready;
   assign push = bus.wr_en && (state != DONE) && (!full || pop);
   assign drop = bus.wr_en && (state != DONE) && full && !pop;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= RUN;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         unique case (state)
            RUN: begin
               if (finished) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if ((count == '0) && !push) begin
                  state <= DONE;
               end
            end
            DONE:    state <= DONE;
            default: state <= RUN;
         endcase
      end
   end

`ifdef OUT_DRAIN_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         words_out <= '0;
      end else if (pop && (words_out != 16'hFFFF)) begin
         words_out <= words_out + 16'd1;
      end
   end
`endif

endmodule
